seq_addsub: RTL and testbench

//  Parametrised multi-cycle two's-complement adder/subtractor with signed-overflow detection.

---
 rtl/seq_addsub_pkg.sv | 11 +
 rtl/seq_addsub_if.sv | 18 +
 rtl/seq_addsub_chunk.sv | 21 ++
 rtl/seq_addsub.sv | 77 +++++++
 tb/tb_seq_addsub.sv | 261 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/seq_addsub_pkg.sv
// seq_addsub_pkg: shared FSM states, opcodes and counter sizing for seq_addsub
package seq_addsub_pkg;
  typedef enum logic [1:0] {ST_IDLE, ST_BUSY, ST_DONE} state_t;
  localparam logic OP_ADD = 1'b0;
  localparam logic OP_SUB = 1'b1;
  function automatic int clog2(input int n);
    int r = 0;
    for (int i = 0; i < 31; i++) if ((1 << i) < n) r = i + 1;
    return r;
  endfunction
endpackage

// File: rtl/seq_addsub_if.sv
// seq_addsub_if: request/response bus of seq_addsub
//   request : in_valid, in_ready, a, b, opcode (0 add, 1 sub)
//   response: out_valid, out_ready, res, cout, ovf
//   modports: master = operand source / result consumer, slave = seq_addsub
interface seq_addsub_if #(parameter int WIDTH = 8);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             opcode;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] res;
  logic             cout;
  logic             ovf;
  modport master (output in_valid, a, b, opcode, out_ready, input in_ready, out_valid, res, cout, ovf);
  modport slave  (input in_valid, a, b, opcode, out_ready, output in_ready, out_valid, res, cout, ovf);
endinterface

// File: rtl/seq_addsub_chunk.sv
// addsub_chunk: combinational CHUNK-bit ripple-carry slice
//   a, b, cin -> s, cout (carry out of slice), c_msb_in (carry into slice MSB)
module addsub_chunk #(
  parameter int CHUNK = 2
) (
  input  logic [CHUNK-1:0] a,
  input  logic [CHUNK-1:0] b,
  input  logic             cin,
  output logic [CHUNK-1:0] s,
  output logic             cout,
  output logic             c_msb_in
);
  logic [CHUNK:0] c;
  assign c[0] = cin;
  for (genvar i = 0; i < CHUNK; i++) begin : g_bit
    assign s[i]   = a[i] ^ b[i] ^ c[i];
    assign c[i+1] = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
  end
  assign cout     = c[CHUNK];
  assign c_msb_in = c[CHUNK-1];
endmodule

// File: rtl/seq_addsub.sv
// seq_addsub: multi-cycle two's-complement add/sub, CHUNK bits per clock, LSB first
//   clk, rst_n (async active-low), bus (seq_addsub_if.slave)
//   optional SEQ_ADDSUB_SAT_EN: saturate res on signed overflow
module seq_addsub
  import seq_addsub_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int CHUNK = 2
) (
  input logic         clk,
  input logic         rst_n,
  seq_addsub_if.slave bus
);
  localparam int NCHUNK = WIDTH / CHUNK;
  localparam int CW = NCHUNK > 1 ? clog2(NCHUNK) : 1;
  state_t           state, state_n;
  logic [WIDTH-1:0] a_q, b_q, r_q;
  logic [CW-1:0]    cnt;
  logic             carry, cout_q, ovf_q, last;
  logic [CHUNK-1:0] s;
  logic             c_out, c_msb;
  addsub_chunk #(.CHUNK(CHUNK)) u_chunk (
    .a       (a_q[cnt*CHUNK +: CHUNK]),
    .b       (b_q[cnt*CHUNK +: CHUNK]),
    .cin     (carry),
    .s       (s),
    .cout    (c_out),
    .c_msb_in(c_msb)
  );
  assign last = cnt == CW'(NCHUNK - 1);
  always_comb begin
    state_n       = state;
    bus.in_ready  = state == ST_IDLE;
    bus.out_valid = state == ST_DONE;
    state_n = state == ST_IDLE ? (bus.in_valid ? ST_BUSY : ST_IDLE)
            : state == ST_BUSY ? (last ? ST_DONE : ST_BUSY)
            : state == ST_DONE ? (bus.out_ready ? ST_IDLE : ST_DONE)
            : ST_IDLE;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= ST_IDLE;
      a_q    <= '0;
      b_q    <= '0;
      r_q    <= '0;
      cnt    <= '0;
      carry  <= 1'b0;
      cout_q <= 1'b0;
      ovf_q  <= 1'b0;
    end else begin
      state <= state_n;
      if (state == ST_IDLE && bus.in_valid) begin
        a_q   <= bus.a;
        b_q   <= bus.b ^ {WIDTH{bus.opcode == OP_SUB}};
        carry <= bus.opcode == OP_SUB;
        cnt   <= '0;
      end
      if (state == ST_BUSY) begin
        r_q[cnt*CHUNK +: CHUNK] <= s;
        carry <= c_out;
        cnt   <= cnt + 1'b1;
        if (last) begin
          cout_q <= c_out;
          ovf_q  <= c_out ^ c_msb;
        end
      end
    end
  end
  assign bus.cout = cout_q;
  assign bus.ovf  = ovf_q;
`ifdef SEQ_ADDSUB_SAT_EN
  // a_q still holds operand A, so its MSB is the latched sign that picks the rail
  assign bus.res = ovf_q ? {a_q[WIDTH-1], {(WIDTH-1){~a_q[WIDTH-1]}}} : r_q;
`else
  assign bus.res = r_q;
`endif
endmodule

// File: tb/tb_seq_addsub.sv
// tb_seq_addsub: self-checking bench for seq_addsub (8/2 and 16/4 instances)
module tb_seq_addsub;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_cmp = 0;
  int   n_err = 0;
  time  t_acc;
  always #5 clk = ~clk;
  seq_addsub_if #(.WIDTH(8))  n_if ();
  seq_addsub_if #(.WIDTH(16)) w_if ();
  seq_addsub #(.WIDTH(8), .CHUNK(2)) u_n (.clk(clk), .rst_n(rst_n), .bus(n_if.slave));
  seq_addsub #(.WIDTH(16), .CHUNK(4)) u_w (.clk(clk), .rst_n(rst_n), .bus(w_if.slave));

  function automatic void model(input int w, input int a, input int b, input bit op,
                                output int r, output bit c, output bit o);
    int m = 1 << w;
    int h = 1 << (w - 1);
    int sa = a >= h ? a - m : a;
    int sb = b >= h ? b - m : b;
    int full = op ? sa - sb : sa + sb;
    o = full < -h || full > h - 1;
    c = op ? (a >= b) : (a + b >= m);
    r = (full + 2 * m) % m;
`ifdef SEQ_ADDSUB_SAT_EN
    if (o) r = sa < 0 ? h : h - 1;
`endif
  endfunction

  task automatic run_op(input bit wide, input int a, input int b, input bit op, input int dly,
                        output int lat, output int r, output bit c, output bit o);
    int n = 0;
    @(negedge clk);
    while (!(wide ? w_if.in_ready : n_if.in_ready) && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (wide) begin
      w_if.a = 16'(a); w_if.b = 16'(b); w_if.opcode = op; w_if.in_valid = 1'b1;
    end else begin
      n_if.a = 8'(a); n_if.b = 8'(b); n_if.opcode = op; n_if.in_valid = 1'b1;
    end
    @(posedge clk);
    t_acc = $time;
    #1;
    n_if.in_valid = 1'b0;
    w_if.in_valid = 1'b0;
    lat = 0;
    while (!(wide ? w_if.out_valid : n_if.out_valid) && lat < 50) begin
      @(posedge clk);
      #1;
      lat++;
    end
    if (n == 50) lat = -1;
    r = wide ? int'(w_if.res) : int'(n_if.res);
    c = wide ? w_if.cout : n_if.cout;
    o = wide ? w_if.ovf : n_if.ovf;
    repeat (dly) @(posedge clk);
    @(negedge clk);
    if (wide) w_if.out_ready = 1'b1; else n_if.out_ready = 1'b1;
    @(posedge clk);
    #1;
    n_if.out_ready = 1'b0;
    w_if.out_ready = 1'b0;
  endtask

  task automatic test_reset();
    n_if.in_valid = 0; n_if.a = 0; n_if.b = 0; n_if.opcode = 0; n_if.out_ready = 0;
    w_if.in_valid = 0; w_if.a = 0; w_if.b = 0; w_if.opcode = 0; w_if.out_ready = 0;
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    n_cmp++;
    if ({n_if.in_ready, n_if.out_valid, n_if.res, n_if.cout, n_if.ovf} !== {1'b1, 1'b0, 8'h00, 1'b0, 1'b0}) begin
      n_err++;
      $display("FAIL reset8: rdy=%b vld=%b res=%h c=%b o=%b, want rdy=1 vld=0 res=00 c=0 o=0",
               n_if.in_ready, n_if.out_valid, n_if.res, n_if.cout, n_if.ovf);
    end
    n_cmp++;
    if ({w_if.in_ready, w_if.out_valid, w_if.res, w_if.cout, w_if.ovf} !== {1'b1, 1'b0, 16'h0000, 1'b0, 1'b0}) begin
      n_err++;
      $display("FAIL reset16: rdy=%b vld=%b res=%h c=%b o=%b, want rdy=1 vld=0 res=0000 c=0 o=0",
               w_if.in_ready, w_if.out_valid, w_if.res, w_if.cout, w_if.ovf);
    end
  endtask

  task automatic test_directed();
    int da[4] = '{50, 100, 8'h80, 0};
    int db[4] = '{10, 100, 1, 0};
    bit dop[4] = '{1, 0, 1, 1};
`ifdef SEQ_ADDSUB_SAT_EN
    int er[4] = '{40, 8'h7F, 8'h80, 0};
`else
    int er[4] = '{40, 8'hC8, 8'h7F, 0};
`endif
    bit ec[4] = '{1, 0, 1, 1};
    bit eo[4] = '{0, 1, 1, 0};
    int lat, r;
    bit c, o;
    for (int i = 0; i < 4; i++) begin
      run_op(1'b0, da[i], db[i], dop[i], 0, lat, r, c, o);
      n_cmp++;
      if (lat !== 4) begin
        n_err++;
        $display("FAIL dir%0d_latency: got %0d cycles, want 4", i, lat);
      end
      n_cmp++;
      if (r !== er[i] || c !== ec[i] || o !== eo[i]) begin
        n_err++;
        $display("FAIL dir%0d_result: res=%h c=%b o=%b, want res=%h c=%b o=%b", i, r, c, o, er[i], ec[i], eo[i]);
      end
    end
  endtask

  task automatic test_hold();
    int n = 0;
    @(negedge clk);
    n_if.a = 8'd0; n_if.b = 8'd0; n_if.opcode = 1'b1; n_if.in_valid = 1'b1;
    @(posedge clk);
    #1;
    n_if.in_valid = 1'b0;
    while (!n_if.out_valid && n < 50) begin
      @(posedge clk);
      #1;
      n++;
    end
    n_cmp++;
    if (n !== 4) begin
      n_err++;
      $display("FAIL hold_latency: got %0d cycles, want 4", n);
    end
    n_if.a = 8'h33; n_if.b = 8'h11; n_if.opcode = 1'b0; n_if.in_valid = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(posedge clk);
      #1;
      n_cmp++;
      if ({n_if.out_valid, n_if.in_ready, n_if.res, n_if.cout, n_if.ovf} !== {1'b1, 1'b0, 8'h00, 1'b1, 1'b0}) begin
        n_err++;
        $display("FAIL hold_cycle%0d: vld=%b rdy=%b res=%h c=%b o=%b, want vld=1 rdy=0 res=00 c=1 o=0",
                 k, n_if.out_valid, n_if.in_ready, n_if.res, n_if.cout, n_if.ovf);
      end
    end
    @(negedge clk);
    n_cmp++;
    if (n_if.in_ready !== 1'b0) begin
      n_err++;
      $display("FAIL hold_no_same_cycle_accept: in_ready=%b, want 0", n_if.in_ready);
    end
    n_if.in_valid = 1'b0;
    n_if.out_ready = 1'b1;
    @(posedge clk);
    #1;
    n_if.out_ready = 1'b0;
    n_cmp++;
    if ({n_if.in_ready, n_if.out_valid} !== 2'b10) begin
      n_err++;
      $display("FAIL hold_release: rdy=%b vld=%b, want rdy=1 vld=0", n_if.in_ready, n_if.out_valid);
    end
  endtask

  task automatic test_mid_reset();
    int lat, r, er;
    bit c, o, ec, eo;
    @(negedge clk);
    n_if.a = 8'h40; n_if.b = 8'h40; n_if.opcode = 1'b0; n_if.in_valid = 1'b1;
    @(posedge clk);
    #1;
    n_if.in_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    n_cmp++;
    if ({n_if.out_valid, n_if.in_ready, n_if.res} !== {1'b0, 1'b1, 8'h00}) begin
      n_err++;
      $display("FAIL midreset_async: vld=%b rdy=%b res=%h, want vld=0 rdy=1 res=00",
               n_if.out_valid, n_if.in_ready, n_if.res);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    n_cmp++;
    if ({n_if.out_valid, n_if.in_ready} !== 2'b01) begin
      n_err++;
      $display("FAIL midreset_release: vld=%b rdy=%b, want vld=0 rdy=1", n_if.out_valid, n_if.in_ready);
    end
    run_op(1'b0, 5, 15, 1'b1, 1, lat, r, c, o);
    model(8, 5, 15, 1'b1, er, ec, eo);
    n_cmp++;
    if (r !== 8'hF6 || r !== er || c !== ec || o !== eo || lat !== 4) begin
      n_err++;
      $display("FAIL midreset_next_op: res=%h c=%b o=%b lat=%0d, want res=f6 c=%b o=%b lat=4", r, c, o, lat, ec, eo);
    end
  endtask

  task automatic test_wide();
    int lat, r;
    bit c, o;
`ifdef SEQ_ADDSUB_SAT_EN
    int er = 16'h7FFF;
`else
    int er = 16'h8000;
`endif
    run_op(1'b1, 16'h7FFF, 1, 1'b0, 0, lat, r, c, o);
    n_cmp++;
    if (r !== er || o !== 1'b1 || c !== 1'b0 || lat !== 4) begin
      n_err++;
      $display("FAIL wide_ovf: res=%h o=%b c=%b lat=%0d, want res=%h o=1 c=0 lat=4", r, o, c, lat, er);
    end
  endtask

  task automatic test_random();
    int lat, r, er, a, b;
    bit c, o, ec, eo, op, wide;
    for (int i = 0; i < 60; i++) begin
      wide = i >= 40;
      a = wide ? int'($urandom_range(16'hFFFF)) : int'($urandom_range(8'hFF));
      b = wide ? int'($urandom_range(16'hFFFF)) : int'($urandom_range(8'hFF));
      op = 1'($urandom_range(1));
      run_op(wide, a, b, op, int'($urandom_range(3)), lat, r, c, o);
      model(wide ? 16 : 8, a, b, op, er, ec, eo);
      n_cmp++;
      if (r !== er || c !== ec || o !== eo || lat !== 4) begin
        n_err++;
        $display("FAIL rand%0d w=%0d a=%h b=%h op=%b: res=%h c=%b o=%b lat=%0d, want res=%h c=%b o=%b lat=4",
                 i, wide ? 16 : 8, a, b, op, r, c, o, lat, er, ec, eo);
      end
    end
  endtask

  task automatic test_back_to_back();
    int lat, r;
    bit c, o;
    time t0;
    run_op(1'b0, 1, 2, 1'b0, 0, lat, r, c, o);
    for (int i = 0; i < 3; i++) begin
      t0 = t_acc;
      run_op(1'b0, 7 * i, 3, 1'b1, 0, lat, r, c, o);
      n_cmp++;
      if (t_acc - t0 !== 60) begin
        n_err++;
        $display("FAIL b2b%0d_spacing: got %0t time units between accepts, want 60", i, t_acc - t0);
      end
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_hold();
    test_mid_reset();
    test_wide();
    test_random();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
